// File: rtl/apple_video_fetch.sv
// apple_video_fetch: fetches one Apple II video scanline from SDRAM into a ping-pong line buffer.
// Optional aborted-line counter enabled by APPLE_VIDEO_FETCH_OVERRUN_CNT_EN.
module apple_video_fetch #(
    parameter int LINE_WORDS      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_logic,
    input  logic                          system_reset,
    input  logic                          line_start_i,
    input  logic [15:0]                   base_addr_i,
    input  logic                          bank_i,
    input  logic [$clog2(LINE_WORDS):0]   word_count_i,
    output logic                          mem_rd_o,
    output logic [20:0]                   mem_addr_o,
    input  logic                          mem_ready_i,
    input  logic                          mem_q_valid_i,
    input  logic [31:0]                   mem_q_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_addr_i,
    output logic [31:0]                   rd_data_o,
    output logic                          busy_o,
    output logic                          line_done_o,
    output logic [15:0]                   overrun_count_o
);
    localparam int AW = $clog2(LINE_WORDS);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, ABORT_DRAIN = 2'd2;

    logic [1:0]    state;
    logic          fill_sel, bank;
    logic [14:0]   word_addr;
    logic [CW-1:0] count, issued, resp_idx, resp_next;
    logic [3:0]    outstanding, out_next;
    logic          accept, resp, write;
    logic [31:0]   line_buf [2*LINE_WORDS];

    assign mem_rd_o   = state == FETCH && issued < count && outstanding < 4'(MAX_OUTSTANDING);
    assign mem_addr_o = {5'b0, bank, word_addr};
    assign busy_o     = state != IDLE;
    assign accept     = mem_rd_o && mem_ready_i;
    // responses with nothing outstanding are stray and must not disturb the count
    assign resp       = mem_q_valid_i && outstanding != 4'd0;
    assign write      = resp && state == FETCH;
    assign out_next   = outstanding + 4'(accept) - 4'(resp);
    assign resp_next  = resp_idx + CW'(write);

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state       <= IDLE;
            fill_sel    <= 1'b0;
            bank        <= 1'b0;
            word_addr   <= 15'd0;
            count       <= '0;
            issued      <= '0;
            resp_idx    <= '0;
            outstanding <= 4'd0;
            line_done_o <= 1'b0;
        end else begin
            line_done_o <= 1'b0;
            outstanding <= out_next;
            if (accept) begin
                word_addr <= word_addr + 15'd1;
                issued    <= issued + CW'(1);
            end
            if (write) resp_idx <= resp_next;
            if (line_start_i) begin
                bank      <= bank_i;
                word_addr <= 15'(base_addr_i >> 1);
                count     <= word_count_i;
                issued    <= '0;
                resp_idx  <= '0;
                // an aborted line keeps filling the same half so the displayed half stays intact
                if (state == IDLE) begin
                    fill_sel    <= ~fill_sel;
                    state       <= word_count_i == '0 ? IDLE : FETCH;
                    line_done_o <= word_count_i == '0;
                end else begin
                    state <= (state == FETCH && out_next == 4'd0) ? FETCH : ABORT_DRAIN;
                end
            end else if (state == FETCH && resp_next == count) begin
                state       <= IDLE;
                line_done_o <= 1'b1;
            end else if (state == ABORT_DRAIN && out_next == 4'd0) begin
                state <= FETCH;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (write) line_buf[{fill_sel, resp_idx[AW-1:0]}] <= mem_q_i;
        rd_data_o <= line_buf[{~fill_sel, rd_addr_i}];
    end

`ifdef APPLE_VIDEO_FETCH_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
    always_ff @(posedge clk_logic) begin
        if (system_reset) overrun_cnt <= 16'd0;
        else if (line_start_i && state != IDLE && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
    end
    assign overrun_count_o = overrun_cnt;
`else
    assign overrun_count_o = 16'h0;
`endif
endmodule

// File: tb/tb_apple_video_fetch.sv
// tb_apple_video_fetch: directed tests of apple_video_fetch against an in-order 3-cycle SDRAM model.
module tb_apple_video_fetch;
    logic        clk_logic = 1'b0, system_reset = 1'b1, line_start_i = 1'b0, bank_i = 1'b0;
    logic        mem_ready_i = 1'b1, mem_q_valid_i = 1'b0;
    logic [15:0] base_addr_i = 16'h0;
    logic [6:0]  word_count_i = 7'd0;
    logic [31:0] mem_q_i = 32'h0;
    logic [5:0]  rd_addr_i = 6'd0;
    logic        mem_rd_o, busy_o, line_done_o;
    logic [20:0] mem_addr_o;
    logic [31:0] rd_data_o;
    logic [15:0] overrun_count_o;

    apple_video_fetch dut (
        .clk_logic(clk_logic), .system_reset(system_reset), .line_start_i(line_start_i),
        .base_addr_i(base_addr_i), .bank_i(bank_i), .word_count_i(word_count_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
        .mem_q_valid_i(mem_q_valid_i), .mem_q_i(mem_q_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .busy_o(busy_o), .line_done_o(line_done_o),
        .overrun_count_o(overrun_count_o)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct {int due; logic [31:0] data;} resp_t;
    resp_t       rq[$];
    logic [20:0] acc_log[$];
    int          cyc = 0, max_out = 0, done_cnt = 0, rd_cnt = 0, unstable = 0;
    int          checks = 0, errors = 0;
    bit          ready_toggle = 0, pending = 0;
    logic [20:0] prev_addr = '0;

    function automatic logic [31:0] dat(input logic [20:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // memory model and monitor: everything happens on the falling edge
    initial forever begin
        @(negedge clk_logic);
        cyc++;
        mem_ready_i = ready_toggle ? cyc[0] : 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_q_valid_i = 1'b1;
            mem_q_i = rq[0].data;
            void'(rq.pop_front());
        end else begin
            mem_q_valid_i = 1'b0;
            mem_q_i = 32'h0;
        end
        if (pending && (mem_rd_o !== 1'b1 || mem_addr_o !== prev_addr)) unstable++;
        if (mem_rd_o && mem_ready_i) begin
            acc_log.push_back(mem_addr_o);
            rq.push_back('{cyc + 3, dat(mem_addr_o)});
            pending = 0;
        end else pending = mem_rd_o;
        prev_addr = mem_addr_o;
        if (rq.size() > max_out) max_out = rq.size();
        if (line_done_o) done_cnt++;
        if (mem_rd_o) rd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_line(input logic [15:0] b, input logic bk, input int n);
        @(negedge clk_logic);
        line_start_i = 1'b1; base_addr_i = b; bank_i = bk; word_count_i = 7'(n);
        @(negedge clk_logic);
        line_start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int t = 0;
        while (done_cnt == d0 && t < 400) begin
            @(posedge clk_logic); #1;
            t++;
        end
        repeat (4) @(posedge clk_logic);
        #1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL %s line_done: got %0d pulses, want 1", nm, done_cnt - d0);
        end
    endtask

    task automatic test_display(input logic [20:0] a0, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_logic);
            rd_addr_i = 6'(i);
            @(negedge clk_logic);
            checks++;
            if (rd_data_o !== dat(a0 + 21'(i))) begin
                errors++;
                $display("FAIL %s display[%0d]: got %h, want %h", nm, i, rd_data_o, dat(a0 + 21'(i)));
            end
        end
    endtask

    task automatic test_reset;
        system_reset = 1'b1;
        repeat (3) @(negedge clk_logic);
        checks++;
        if ({mem_rd_o, mem_addr_o, busy_o, line_done_o, overrun_count_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: rd=%b addr=%h busy=%b done=%b ovr=%h, want all 0",
                     mem_rd_o, mem_addr_o, busy_o, line_done_o, overrun_count_o);
        end
        system_reset = 1'b0;
    endtask

    task automatic test_line(input logic [15:0] b, input logic bk, input int n, input logic [20:0] a0,
                             input string nm);
        int d0 = done_cnt;
        acc_log.delete();
        max_out = 0;
        start_line(b, bk, n);
        wait_done(d0, nm);
        checks++;
        if (acc_log.size() != n) begin
            errors++;
            $display("FAIL %s request count: got %0d, want %0d", nm, acc_log.size(), n);
        end
        for (int i = 0; i < n && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i] !== a0 + 21'(i)) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %h, want %h", nm, i, acc_log[i], a0 + 21'(i));
            end
        end
        checks++;
        if (max_out > 4 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s outstanding/busy: max %0d busy %b, want <=4 and 0", nm, max_out, busy_o);
        end
    endtask

    task automatic test_count0(input logic [20:0] a0, input int n, input string nm);
        int r0 = rd_cnt;
        @(negedge clk_logic);
        line_start_i = 1'b1; base_addr_i = 16'h1234; bank_i = 1'b0; word_count_i = 7'd0;
        @(negedge clk_logic);
        line_start_i = 1'b0;
        checks++;
        if (line_done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s count0 done: got %b, want 1", nm, line_done_o);
        end
        @(negedge clk_logic);
        checks++;
        if (line_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s count0 after: done %b busy %b, want 0 0", nm, line_done_o, busy_o);
        end
        repeat (3) @(posedge clk_logic);
        #1;
        checks++;
        if (rd_cnt != r0) begin
            errors++;
            $display("FAIL %s count0 mem_rd: got %0d cycles high, want 0", nm, rd_cnt - r0);
        end
        test_display(a0, n, nm);
    endtask

    task automatic test_wrap;
        logic [20:0] exp_a[4] = '{21'h0FFFE, 21'h0FFFF, 21'h08000, 21'h08001};
        int d0 = done_cnt;
        acc_log.delete();
        start_line(16'hFFFC, 1'b1, 4);
        wait_done(d0, "wrap");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_log.size() <= i || acc_log[i] !== exp_a[i]) begin
                errors++;
                $display("FAIL wrap addr[%0d]: got %h, want %h", i,
                         acc_log.size() > i ? acc_log[i] : 21'h1FFFFF, exp_a[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        ready_toggle = 1;
        unstable = 0;
        test_line(16'h0400, 1'b0, 10, 21'h00200, "backpressure");
        ready_toggle = 0;
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL backpressure stability: got %0d changes while unaccepted, want 0", unstable);
        end
    endtask

    task automatic test_overrun;
        int d0 = done_cnt;
        logic [15:0] o0 = overrun_count_o;
        logic [15:0] exp_ov;
        acc_log.delete();
        max_out = 0;
        start_line(16'h3000, 1'b0, 16);
        repeat (3) @(negedge clk_logic);
        line_start_i = 1'b1; base_addr_i = 16'h5000; bank_i = 1'b1; word_count_i = 7'd8;
        @(negedge clk_logic);
        line_start_i = 1'b0;
        checks++;
        if (mem_rd_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun drop: rd %b busy %b, want 0 1", mem_rd_o, busy_o);
        end
        wait_done(d0, "overrun");
        checks++;
        if (acc_log.size() != 12) begin
            errors++;
            $display("FAIL overrun request count: got %0d, want 12", acc_log.size());
        end
        for (int i = 0; i < 12 && i < acc_log.size(); i++) begin
            logic [20:0] e = i < 4 ? 21'h01800 + 21'(i) : 21'h0A800 + 21'(i - 4);
            checks++;
            if (acc_log[i] !== e) begin
                errors++;
                $display("FAIL overrun addr[%0d]: got %h, want %h", i, acc_log[i], e);
            end
        end
`ifdef APPLE_VIDEO_FETCH_OVERRUN_CNT_EN
        exp_ov = o0 + 16'd1;
`else
        exp_ov = 16'd0;
`endif
        checks++;
        if (overrun_count_o !== exp_ov || max_out > 4) begin
            errors++;
            $display("FAIL overrun count: got %h (max out %0d), want %h", overrun_count_o, max_out, exp_ov);
        end
        test_count0(21'h0A800, 8, "overrun");
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt;
        start_line(16'h2000, 1'b0, 20);
        repeat (4) @(negedge clk_logic);
        system_reset = 1'b1;
        @(negedge clk_logic);
        system_reset = 1'b0;
        checks++;
        if ({mem_rd_o, mem_addr_o, busy_o, line_done_o, overrun_count_o} !== '0) begin
            errors++;
            $display("FAIL midreset outputs: rd=%b addr=%h busy=%b done=%b ovr=%h, want all 0",
                     mem_rd_o, mem_addr_o, busy_o, line_done_o, overrun_count_o);
        end
        repeat (10) @(posedge clk_logic);
        #1;
        checks++;
        if (done_cnt != d0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset late data: done pulses %0d busy %b, want 0 0", done_cnt - d0, busy_o);
        end
        test_line(16'h0100, 1'b0, 4, 21'h00080, "postreset");
        test_count0(21'h00080, 4, "postreset");
    endtask

    initial begin
        test_reset();
        test_line(16'h2000, 1'b0, 20, 21'h01000, "basic");
        test_count0(21'h01000, 20, "basic");
        test_wrap();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apple_video_fetch.md
Name: apple_video_fetch

Overview:
- Read-side counterpart to the shadow-memory writer: fetches one scanline of shadowed Apple II video memory from the SDRAM video port into a ping-pong line buffer.
- The scan generator reads completed lines from the buffer at 1-cycle latency while the next line is being fetched.
- Each 32-bit SDRAM word holds two consecutive Apple addresses: byte0 = even/main, byte1 = even/aux, byte2 = odd/main, byte3 = odd/aux.

Parameters:
- LINE_WORDS, 64, depth of each line-buffer half in 32-bit words (power of 2).
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered read requests (1..15).

Ports:
- clk_logic  input  1  logic clock.
- system_reset  input  1  synchronous reset, active-high.
- line_start_i  input  1  one-cycle pulse: begin fetching a new line.
- base_addr_i  input  16  Apple byte address of the line start; bit 0 is ignored. Sampled on line_start_i.
- bank_i  input  1  video bank select. Sampled on line_start_i.
- word_count_i  input  $clog2(LINE_WORDS)+1  words to fetch, 0..LINE_WORDS. Sampled on line_start_i.
- mem_rd_o  output  1  read request.
- mem_addr_o  output  21  SDRAM word address {5'b0, bank, word_addr[14:0]}.
- mem_ready_i  input  1  request accepted on a clock edge where mem_rd_o && mem_ready_i.
- mem_q_valid_i  input  1  read data valid; responses return in request order.
- mem_q_i  input  32  read data.
- rd_addr_i  input  $clog2(LINE_WORDS)  display-side word index.
- rd_data_o  output  32  buffer word, registered, valid 1 cycle after rd_addr_i.
- busy_o  output  1  fetch or abort-drain in progress.
- line_done_o  output  1  one-cycle pulse when every word of the line has been written.
- overrun_count_o  output  16  aborted-line counter (see Optional Feature).

Behaviour:
- Reset: mem_rd_o=0, mem_addr_o=0, busy_o=0, line_done_o=0, overrun_count_o=0, fill_sel=0 (display reads half 1), all counters 0, state IDLE. Buffer contents are not cleared.
- States: IDLE, FETCH, ABORT_DRAIN.
- IDLE, on line_start_i:
  - Capture bank, word_addr=base_addr_i[15:1], remaining=word_count_i; toggle fill_sel; reset req_idx and resp_idx to 0.
  - word_count_i=0: line_done_o pulses the next cycle; no request issued; stay IDLE.
  - Otherwise go to FETCH; mem_rd_o rises the next cycle.
- FETCH requests:
  - mem_rd_o=1 while issued<word_count and outstanding<MAX_OUTSTANDING.
  - mem_addr_o holds stable until accepted.
  - On acceptance: word_addr increments, wrapping modulo 2^15 (bank unchanged); issued++; outstanding++.
- FETCH responses:
  - Each mem_q_valid_i writes mem_q_i to buffer[fill_sel][resp_idx]; resp_idx++; outstanding--.
  - Acceptance and response in the same cycle leave outstanding unchanged.
  - mem_q_valid_i while outstanding=0 is ignored.
- Completion: when resp_idx reaches word_count, line_done_o pulses that next cycle and the state returns to IDLE. busy_o is 1 in FETCH and ABORT_DRAIN, 0 in IDLE.
- Overrun: line_start_i in FETCH or ABORT_DRAIN.
  - Capture new parameters and toggle fill_sel back to the half being filled, so the displayed half is untouched.
  - Drop mem_rd_o the next cycle; increment overrun counter; no line_done_o for the aborted line.
  - If outstanding=0, enter FETCH for the new line; else ABORT_DRAIN.
- ABORT_DRAIN: discard responses, no buffer writes, no requests. When outstanding reaches 0, enter FETCH. A further line_start_i here recaptures parameters and stays in ABORT_DRAIN.
- Display read: rd_data_o <= buffer[~fill_sel][rd_addr_i] every cycle. A same-cycle fill write never targets the read half.

Optional Feature:
- Macro APPLE_VIDEO_FETCH_OVERRUN_CNT_EN.
- Defined: overrun_count_o is a 16-bit saturating count (holds at 16'hFFFF) of aborted lines; cleared only by system_reset.
- Undefined: overrun_count_o is constant 0 and the counter logic is omitted. FSM and abort behaviour are identical either way.

Test Plan:
- Line with base 16'h2000, bank 0, count 20, mem_ready_i=1, 3-cycle response latency -> addresses 21'h01000..21'h01013 in order; outstanding never exceeds 4; line_done_o once; display half then returns the 20 words at indices 0..19.
- Back-pressure: mem_ready_i toggled every other cycle -> mem_addr_o stable while unaccepted; no duplicate or skipped address.
- Wrap: base 16'hFFFC, count 4 -> word addresses 7FFE, 7FFF, 0000, 0001 with bank bit preserved.
- Count 0 -> line_done_o exactly 1 cycle after line_start_i; mem_rd_o stays 0; fill_sel toggles.
- Overrun: second line_start_i with 3 requests outstanding -> those 3 responses are discarded; new line fetched from its base; single line_done_o; overrun_count_o=1 (0 with macro off).
- Reset asserted mid-FETCH -> next cycle all outputs 0 and state IDLE; a late mem_q_valid_i is ignored.
